barrett_arbiter: RTL and testbench

- Shares a single 2-stage Barrett reduction datapath among NREQ requesters, e.g. parallel decode/encode lanes of the codec, each with its own modulus.
- Arbitrates round-robin, issues at most one division per cycle into the pipeline and tracks requester IDs alongside it.
- Returns each quotient/remainder on a broadcast response bus tagged with the issuing requester's ID.
- The Barrett datapath is instantiated inside this block.

---
 rtl/barrett_arbiter_if.sv | 29 ++
 rtl/barrett_arbiter.sv | 156 +++++++++++++++
 tb/tb_barrett_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrett_arbiter_if.sv
// Request/response bundle for barrett_arbiter: packed per-requester operands in,
// one-hot grant and tagged broadcast response out.
interface barrett_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned M0LEN = 14,
  parameter int unsigned SHIFT = 27,
  parameter int unsigned IDW   = 2
) ();
  logic [NREQ-1:0]         req;
  logic [NREQ*2*M0LEN-1:0] req_dividend;
  logic [NREQ*M0LEN-1:0]   req_m0;
  logic [NREQ*SHIFT-1:0]   req_m0_inv;
  logic [NREQ-1:0]         gnt;
  logic                    rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic [M0LEN-1:0]        rsp_quotient;
  logic [M0LEN-1:0]        rsp_remainder;
  logic                    busy;

  modport slave (
    input  req, req_dividend, req_m0, req_m0_inv,
    output gnt, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, busy
  );

  modport master (
    output req, req_dividend, req_m0, req_m0_inv,
    input  gnt, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, busy
  );
endinterface

// File: rtl/barrett_arbiter.sv
// Round-robin arbiter sharing one 2-stage Barrett divider among NREQ requesters.
// Optional statistics counters are enabled by defining BARRETT_ARB_STATS_EN.
module barrett_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned M0LEN = 14,
  parameter int unsigned SHIFT = 27,
  parameter int unsigned IDW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  barrett_arbiter_if.slave    bus
`ifdef BARRETT_ARB_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [31:0]         stat_issued,
  output logic [NREQ*16-1:0]  stat_grant_cnt,
  output logic [31:0]         stat_idle
`endif
);

  localparam int unsigned DW = 2 * M0LEN;
  localparam int unsigned PW = DW + SHIFT;

  logic [IDW-1:0]   r_ptr;
  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_gnt_id;
  logic             w_xfer;
  logic [DW-1:0]    w_dividend;
  logic [M0LEN-1:0] w_m0;
  logic [SHIFT-1:0] w_m0_inv;
  logic             w_busy;

  logic             r_v1;
  logic             r_v2;
  logic [IDW-1:0]   r_id1;
  logic [IDW-1:0]   r_id2;

  logic [DW-1:0]    r_s1_a;
  logic [M0LEN-1:0] r_s1_m0;
  logic [M0LEN-1:0] r_s1_q;
  logic [M0LEN-1:0] r_s2_q;
  logic [M0LEN-1:0] r_s2_r;

  logic [M0LEN-1:0] w_q_est;
  logic [DW-1:0]    w_r_est;
  logic             w_fix;

  function automatic int unsigned rr_idx(input logic [IDW-1:0] p, input int unsigned k);
    return (32'(p) + k) % NREQ;
  endfunction

  // Scan from the pointer upward with wrap; the first asserted request wins.
  always_comb begin
    w_gnt      = '0;
    w_gnt_id   = '0;
    w_xfer     = 1'b0;
    w_dividend = '0;
    w_m0       = '0;
    w_m0_inv   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_xfer && bus.req[rr_idx(r_ptr, k)]) begin
        w_xfer                   = 1'b1;
        w_gnt[rr_idx(r_ptr, k)]  = 1'b1;
        w_gnt_id                 = IDW'(rr_idx(r_ptr, k));
        w_dividend               = bus.req_dividend[rr_idx(r_ptr, k)*DW +: DW];
        w_m0                     = bus.req_m0[rr_idx(r_ptr, k)*M0LEN +: M0LEN];
        w_m0_inv                 = bus.req_m0_inv[rr_idx(r_ptr, k)*SHIFT +: SHIFT];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_id1 <= '0;
      r_id2 <= '0;
    end else begin
      r_v1  <= w_xfer;
      r_v2  <= r_v1;
      r_id1 <= w_gnt_id;
      r_id2 <= r_id1;
    end
  end

  // The estimate never exceeds the true quotient, which fits M0LEN bits.
  assign w_q_est = M0LEN'((PW'(w_dividend) * PW'(w_m0_inv)) >> SHIFT);

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_s1_a  <= w_dividend;
      r_s1_m0 <= w_m0;
      r_s1_q  <= w_q_est;
    end
  end

  // Estimate is low by at most one, so a single conditional subtract finishes.
  assign w_r_est = r_s1_a - DW'(r_s1_q) * DW'(r_s1_m0);
  assign w_fix   = (w_r_est >= DW'(r_s1_m0));

  always_ff @(posedge clk) begin
    if (r_v1) begin
      r_s2_q <= r_s1_q + M0LEN'(w_fix);
      r_s2_r <= w_fix ? M0LEN'(w_r_est - DW'(r_s1_m0)) : M0LEN'(w_r_est);
    end
  end

  assign w_busy            = (|bus.req) | r_v1 | r_v2;
  assign bus.gnt           = w_gnt;
  assign bus.rsp_valid     = r_v2;
  assign bus.rsp_id        = r_id2;
  assign bus.rsp_quotient  = r_s2_q;
  assign bus.rsp_remainder = r_s2_r;
  assign bus.busy          = w_busy;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_gnt));
  a_gnt_has_req: assert property (@(posedge clk) disable iff (!rst_n) (w_gnt & ~bus.req) == '0);

`ifdef BARRETT_ARB_STATS_EN
  logic [31:0]        r_issued;
  logic [31:0]        r_idle;
  logic [NREQ*16-1:0] r_gcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued <= '0;
      r_idle   <= '0;
      r_gcnt   <= '0;
    end else if (stat_clr) begin
      r_issued <= '0;
      r_idle   <= '0;
      r_gcnt   <= '0;
    end else begin
      if (w_xfer) r_issued <= r_issued + 32'd1;
      if (!w_busy) r_idle <= r_idle + 32'd1;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (w_gnt[i] && (r_gcnt[i*16 +: 16] != 16'hFFFF))
          r_gcnt[i*16 +: 16] <= r_gcnt[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign stat_issued    = r_issued;
  assign stat_idle      = r_idle;
  assign stat_grant_cnt = r_gcnt;
`endif

endmodule

// File: tb/tb_barrett_arbiter.sv
// Directed self-checking bench for barrett_arbiter (NREQ=4, M0LEN=14, SHIFT=27).
module tb_barrett_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned M0LEN = 14;
  localparam int unsigned SHIFT = 27;
  localparam int unsigned IDW   = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  barrett_arbiter_if #(.NREQ(NREQ), .M0LEN(M0LEN), .SHIFT(SHIFT), .IDW(IDW)) bus ();

`ifdef BARRETT_ARB_STATS_EN
  logic               stat_clr;
  logic [31:0]        stat_issued;
  logic [NREQ*16-1:0] stat_grant_cnt;
  logic [31:0]        stat_idle;
`endif

  barrett_arbiter #(.NREQ(NREQ), .M0LEN(M0LEN), .SHIFT(SHIFT), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BARRETT_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_issued    (stat_issued),
    .stat_grant_cnt (stat_grant_cnt),
    .stat_idle      (stat_idle)
`endif
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int unsigned i, input logic [27:0] dv,
                        input logic [13:0] m, input logic [26:0] inv);
    bus.req_dividend[i*28 +: 28] = dv;
    bus.req_m0[i*14 +: 14]       = m;
    bus.req_m0_inv[i*27 +: 27]   = inv;
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n            = 1'b0;
    bus.req          = '0;
    bus.req_dividend = '0;
    bus.req_m0       = '0;
    bus.req_m0_inv   = '0;
`ifdef BARRETT_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt_idle got=%b exp=0000", bus.gnt); end
    bus.req = 4'b1111;
    #1;
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL reset_ptr_zero got=%b exp=0001", bus.gnt); end
    bus.req = '0;
    #1;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single;
    bus.req = 4'b0001;
    set_op(0, 28'd100000, 14'd4591, 27'd29234);
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", bus.gnt); end
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1)
      begin failures++; $display("FAIL single_t1 got valid=%b busy=%b exp valid=0 busy=1", bus.rsp_valid, bus.busy); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_quotient !== 14'd21 || bus.rsp_remainder !== 14'd3589)
      begin failures++; $display("FAIL single_rsp got v=%b id=%0d q=%0d r=%0d exp v=1 id=0 q=21 r=3589",
        bus.rsp_valid, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL single_done got valid=%b busy=%b exp valid=0 busy=0", bus.rsp_valid, bus.busy); end
    next_cycle();
  endtask

  task automatic test_boundaries;
    logic [27:0] dv [10];
    logic [13:0] eq [10];
    logic [13:0] er [10];
    dv[0] = 28'd4590;     eq[0] = 14'd0;     er[0] = 14'd4590;
    dv[1] = 28'd4591;     eq[1] = 14'd1;     er[1] = 14'd0;
    dv[2] = 28'd9181;     eq[2] = 14'd1;     er[2] = 14'd4590;
    dv[3] = 28'd75202079; eq[3] = 14'd16380; er[3] = 14'd1499;
    dv[4] = 28'd75205079; eq[4] = 14'd16380; er[4] = 14'd4499;
    for (int i = 5; i < 10; i++) begin
      dv[i] = 28'($urandom_range(0, 75218943));
      eq[i] = 14'(dv[i] / 28'd4591);
      er[i] = 14'(dv[i] % 28'd4591);
    end
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        bus.req = 4'b0010;
        set_op(1, dv[c], 14'd4591, 27'd29234);
      end else begin
        bus.req = '0;
      end
      @(negedge clk);
      if (c < 10) begin
        checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL bound_gnt c=%0d got=%b exp=0010", c, bus.gnt); end
      end
      if (c >= 2) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_quotient !== eq[c-2] || bus.rsp_remainder !== er[c-2])
          begin failures++; $display("FAIL bound_rsp a=%0d got v=%b id=%0d q=%0d r=%0d exp v=1 id=1 q=%0d r=%0d",
            dv[c-2], bus.rsp_valid, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, eq[c-2], er[c-2]); end
      end else begin
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bound_early c=%0d got v=%b exp v=0", c, bus.rsp_valid); end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin;
    logic [13:0] eq [4];
    logic [13:0] er [4];
    logic [3:0]  eg;
    eq[0] = 14'd21;    er[0] = 14'd3589;
    eq[1] = 14'd653;   er[1] = 14'd257;
    eq[2] = 14'd14;    er[2] = 14'd2;
    eq[3] = 14'd16383; er[3] = 14'd16382;
    do_reset();
    set_op(0, 28'd100000,    14'd4591,  27'd29234);
    set_op(1, 28'd1000000,   14'd1531,  27'd87666);
    set_op(2, 28'd100,       14'd7,     27'd19173961);
    set_op(3, 28'd268419071, 14'd16383, 27'd8192);
    for (int c = 0; c < 10; c++) begin
      bus.req = (c < 8) ? 4'b1111 : 4'b0000;
      eg = 4'b0001 << (c % 4);
      @(negedge clk);
      if (c < 8) begin
        checks++; if (bus.gnt !== eg) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.gnt, eg); end
      end
      if (c >= 2) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((c-2) % 4) ||
            bus.rsp_quotient !== eq[(c-2)%4] || bus.rsp_remainder !== er[(c-2)%4])
          begin failures++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d q=%0d r=%0d exp v=1 id=%0d q=%0d r=%0d",
            c, bus.rsp_valid, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, (c-2)%4, eq[(c-2)%4], er[(c-2)%4]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_sparse_wrap;
    bus.req = 4'b0100;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL sparse_setptr got=%b exp=0100", bus.gnt); end
    next_cycle();
    bus.req = 4'b0101;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL sparse_wrap got=%b exp=0001", bus.gnt); end
    next_cycle();
    bus.req = 4'b0100;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL sparse_next got=%b exp=0100", bus.gnt); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_quotient !== 14'd14 || bus.rsp_remainder !== 14'd2)
      begin failures++; $display("FAIL sparse_rsp0 got v=%b id=%0d q=%0d r=%0d exp v=1 id=2 q=14 r=2",
        bus.rsp_valid, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder); end
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1)
      begin failures++; $display("FAIL sparse_idle1 got gnt=%b busy=%b exp gnt=0000 busy=1", bus.gnt, bus.busy); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_quotient !== 14'd21 || bus.rsp_remainder !== 14'd3589)
      begin failures++; $display("FAIL sparse_rsp1 got v=%b id=%0d q=%0d r=%0d exp v=1 id=0 q=21 r=3589",
        bus.rsp_valid, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2)
      begin failures++; $display("FAIL sparse_idle2 got busy=%b v=%b id=%0d exp busy=1 v=1 id=2", bus.busy, bus.rsp_valid, bus.rsp_id); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0)
      begin failures++; $display("FAIL sparse_busy_drop got busy=%b v=%b exp busy=0 v=0", bus.busy, bus.rsp_valid); end
    next_cycle();
  endtask

  task automatic test_reset_midflight;
    bus.req = 4'b0001;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0001) begin failures++; $display("FAIL mid_gnt0 got=%b exp=0001", bus.gnt); end
    next_cycle();
    bus.req = 4'b0010;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_t1 got v=%b exp v=0", bus.rsp_valid); end
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
      begin failures++; $display("FAIL mid_rst_t2 got v=%b busy=%b exp v=0 busy=0", bus.rsp_valid, bus.busy); end
    #2;
    rst_n = 1'b1;
    next_cycle();
    bus.req = 4'b0100;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL mid_after_gnt got=%b exp=0100", bus.gnt); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_after_t3 got v=%b exp v=0", bus.rsp_valid); end
    next_cycle();
    bus.req = '0;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_after_t4 got v=%b exp v=0", bus.rsp_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_quotient !== 14'd14 || bus.rsp_remainder !== 14'd2)
      begin failures++; $display("FAIL mid_after_rsp got v=%b id=%0d q=%0d r=%0d exp v=1 id=2 q=14 r=2",
        bus.rsp_valid, bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder); end
    next_cycle();
  endtask

`ifdef BARRETT_ARB_STATS_EN
  task automatic test_stats;
    logic [3:0] eg;
    do_reset();
    stat_clr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.req = (c < 6) ? 4'b0010 : 4'b1000;
      eg      = bus.req;
      @(negedge clk);
      checks++; if (bus.gnt !== eg) begin failures++; $display("FAIL stats_gnt c=%0d got=%b exp=%b", c, bus.gnt, eg); end
      next_cycle();
    end
    bus.req = '0;
    @(negedge clk);
    checks++; if (stat_issued !== 32'd10) begin failures++; $display("FAIL stats_issued got=%0d exp=10", stat_issued); end
    checks++; if (stat_grant_cnt !== {16'd4, 16'd0, 16'd6, 16'd0})
      begin failures++; $display("FAIL stats_grant_cnt got=%h exp=%h", stat_grant_cnt, {16'd4, 16'd0, 16'd6, 16'd0}); end
    next_cycle();
    bus.req  = 4'b0010;
    stat_clr = 1'b1;
    @(negedge clk);
    checks++; if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL stats_clr_gnt got=%b exp=0010", bus.gnt); end
    next_cycle();
    bus.req  = '0;
    stat_clr = 1'b0;
    @(negedge clk);
    checks++; if (stat_issued !== 32'd0 || stat_grant_cnt !== '0 || stat_idle !== 32'd0)
      begin failures++; $display("FAIL stats_cleared got issued=%0d gcnt=%h idle=%0d exp all 0", stat_issued, stat_grant_cnt, stat_idle); end
    next_cycle();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_round_robin();
    test_sparse_wrap();
    test_reset_midflight();
`ifdef BARRETT_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
